// File: rtl/fetch_decode_sequencer.sv
// Fetch/decode control FSM: FETCH, then DECODE, then one resolve cycle for branch/jump/jr or an EXEC req/done handshake.
// ex_req is held until ex_done, with an optional timeout halt. FDS_PERF_CNT_EN adds the retired_cnt instruction counter.
module fetch_decode_sequencer #(
    parameter logic [5:0]  BREAK_FUNCT = 6'h0D,
    parameter int unsigned EX_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_out,
    input  logic        br_eq,
    input  logic        ex_done,
    output logic        PC_ld,
    output logic        PC_inc,
    output logic [1:0]  PC_sel,
    output logic        IM_cs,
    output logic        IM_rd,
    output logic        IR_ld,
    output logic        ex_req,
    output logic        link_we,
    output logic        halted,
    output logic        err
`ifdef FDS_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    localparam int CW = (EX_TIMEOUT > 1) ? $clog2(EX_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_BRANCH, S_JUMP, S_JR, S_EXEC, S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_dec_state;
    logic [CW-1:0]   r_ex_cnt;
    logic            r_err;
    logic            w_timeout;
    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic            w_unused;

    assign w_opcode  = IR_out[31:26];
    assign w_funct   = IR_out[5:0];
    assign w_unused  = ^IR_out[25:6];
    // Timeout fires on the EX_TIMEOUT-th EXEC cycle without ex_done; ex_done in that cycle still wins.
    assign w_timeout = (EX_TIMEOUT != 0) && (r_ex_cnt == CW'(EX_TIMEOUT - 1));

    always_comb begin
        w_dec_state = S_EXEC;
        case (w_opcode)
            6'h04, 6'h05: w_dec_state = S_BRANCH;
            6'h02, 6'h03: w_dec_state = S_JUMP;
            6'h00: begin
                if (w_funct == 6'h08)
                    w_dec_state = S_JR;
                else if (w_funct == BREAK_FUNCT)
                    w_dec_state = S_HALT;
            end
            default: w_dec_state = S_EXEC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ex_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= w_dec_state;
                S_BRANCH, S_JUMP, S_JR: r_state <= S_FETCH;
                S_EXEC: begin
                    if (ex_done) begin
                        r_state  <= S_FETCH;
                        r_ex_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state  <= S_HALT;
                        r_err    <= 1'b1;
                        r_ex_cnt <= '0;
                    end else begin
                        r_ex_cnt <= r_ex_cnt + CW'(1);
                    end
                end
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PC_ld   = 1'b0;
        PC_inc  = 1'b0;
        PC_sel  = 2'b00;
        IM_cs   = 1'b0;
        IM_rd   = 1'b0;
        IR_ld   = 1'b0;
        ex_req  = 1'b0;
        link_we = 1'b0;
        halted  = 1'b0;
        err     = 1'b0;
        case (r_state)
            S_FETCH: begin
                IM_cs  = 1'b1;
                IM_rd  = 1'b1;
                IR_ld  = 1'b1;
                PC_inc = 1'b1;
            end
            S_BRANCH: PC_ld = (w_opcode == 6'h04) ? br_eq : ~br_eq;
            S_JUMP: begin
                PC_sel  = 2'b01;
                PC_ld   = 1'b1;
                link_we = (w_opcode == 6'h03);
            end
            S_JR: begin
                PC_sel = 2'b11;
                PC_ld  = 1'b1;
            end
            S_EXEC: ex_req = 1'b1;
            S_HALT: begin
                halted = 1'b1;
                err    = r_err;
            end
            default: ;
        endcase
    end

`ifdef FDS_PERF_CNT_EN
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = (r_state == S_BRANCH) || (r_state == S_JUMP) || (r_state == S_JR) ||
                      ((r_state == S_EXEC) && ex_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + 32'd1;
    end

    assign retired_cnt = r_retired;
`endif

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// Bench for fetch_decode_sequencer: driver pushes per-cycle expected outputs from an instruction-level model,
// a monitor pops and compares them on the falling edge.
module tb_fetch_decode_sequencer;

    localparam int unsigned TO = 16;
    localparam int K_BR = 0, K_J = 1, K_JR = 2, K_BRK = 3, K_EX = 4;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       im_cs;
        logic       im_rd;
        logic       ir_ld;
        logic       ex_req;
        logic       link_we;
        logic       halted;
        logic       err;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IR_out = '0;
    logic        br_eq = 1'b0;
    logic        ex_done = 1'b0;
    logic        PC_ld, PC_inc, IM_cs, IM_rd, IR_ld, ex_req, link_we, halted, err;
    logic [1:0]  PC_sel;
`ifdef FDS_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_cnt = 0;
    int          cyc_no = 0;

    fetch_decode_sequencer #(.BREAK_FUNCT(6'h0D), .EX_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .IR_out(IR_out), .br_eq(br_eq), .ex_done(ex_done),
        .PC_ld(PC_ld), .PC_inc(PC_inc), .PC_sel(PC_sel), .IM_cs(IM_cs), .IM_rd(IM_rd),
        .IR_ld(IR_ld), .ex_req(ex_req), .link_we(link_we), .halted(halted), .err(err)
`ifdef FDS_PERF_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t z();
        exp_t e;
        e.c   = '0;
        e.cnt = m_cnt;
        return e;
    endfunction

    function automatic int kind(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h04 || op == 6'h05) return K_BR;
        if (op == 6'h02 || op == 6'h03) return K_J;
        if (op == 6'h00 && fn == 6'h08) return K_JR;
        if (op == 6'h00 && fn == 6'h0D) return K_BRK;
        return K_EX;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input exp_t e, input logic done);
        @(posedge clk);
        #1;
        ex_done = done;
        q.push_back(e);
    endtask

    // Assert reset mid-cycle (outputs must clear before the next edge), hold a cycle, release in IDLE.
    task automatic reset_now();
        @(posedge clk);
        #1;
        ex_done = 1'b0;
        #1;
        reset = 1'b0;
        m_cnt = 0;
        q.push_back(z());
        cyc(z(), rbit());
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.push_back(z());
    endtask

    // lat: EXEC cycles until ex_done (0 = never, timeout); abort: reset after the first EXEC cycle.
    task automatic run_instr(input logic [31:0] ir, input logic br, input int lat, input bit abort);
        exp_t e;
        e = z();
        e.c.im_cs = 1'b1; e.c.im_rd = 1'b1; e.c.ir_ld = 1'b1; e.c.pc_inc = 1'b1;
        @(posedge clk);
        #1;
        IR_out  = ir;
        br_eq   = br;
        ex_done = rbit();
        q.push_back(e);
        cyc(z(), rbit());
        case (kind(ir))
            K_BR: begin
                e = z();
                e.c.pc_ld = (ir[31:26] == 6'h04) ? br : ~br;
                cyc(e, rbit());
                m_cnt++;
            end
            K_J: begin
                e = z();
                e.c.pc_sel = 2'b01; e.c.pc_ld = 1'b1;
                e.c.link_we = (ir[31:26] == 6'h03);
                cyc(e, rbit());
                m_cnt++;
            end
            K_JR: begin
                e = z();
                e.c.pc_sel = 2'b11; e.c.pc_ld = 1'b1;
                cyc(e, rbit());
                m_cnt++;
            end
            K_BRK: begin
                for (int i = 0; i < 20; i++) begin
                    e = z(); e.c.halted = 1'b1;
                    cyc(e, 1'(i));
                end
                reset_now();
            end
            default: begin
                e = z(); e.c.ex_req = 1'b1;
                if (abort) begin
                    cyc(e, 1'b0);
                    reset_now();
                end else if (lat == 0) begin
                    for (int i = 0; i < int'(TO); i++) cyc(e, 1'b0);
                    for (int i = 0; i < 6; i++) begin
                        e = z(); e.c.halted = 1'b1; e.c.err = 1'b1;
                        cyc(e, rbit());
                    end
                    reset_now();
                end else begin
                    for (int i = 1; i <= lat; i++) cyc(e, (i == lat));
                    m_cnt++;
                end
            end
        endcase
    endtask

    initial begin : monitor
        exp_t e;
        ctl_t a;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {PC_ld, PC_inc, PC_sel, IM_cs, IM_rd, IR_ld, ex_req, link_we, halted, err};
                n_cmp++;
                if (a !== e.c) begin
                    n_bad++;
                    $display("FAIL ctl cycle %0d IR=%h: got %b expected %b (pc_ld pc_inc sel cs rd ir_ld req link halt err)",
                             cyc_no, IR_out, a, e.c);
                end
`ifdef FDS_PERF_CNT_EN
                n_cmp++;
                if (retired_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL retired_cnt cycle %0d: got %0d expected %0d", cyc_no, retired_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin : driver
        logic [31:0] ir;
        int          r;
        reset_now();
        run_instr(32'h00000000, 1'b0, 3, 1'b0);
        run_instr(32'h1000FFFF, 1'b1, 0, 1'b0);
        run_instr(32'h1000FFFF, 1'b0, 0, 1'b0);
        run_instr(32'h1400FFFF, 1'b0, 0, 1'b0);
        run_instr(32'h0C000010, 1'b0, 0, 1'b0);
        run_instr(32'h03E00008, 1'b0, 0, 1'b0);
        run_instr(32'h0000000D, 1'b0, 0, 1'b0);
        run_instr(32'h20010005, 1'b0, 0, 1'b0);
        run_instr(32'h0C000010, 1'b0, 0, 1'b0);
        run_instr(32'h1000FFFF, 1'b1, 0, 1'b0);
        run_instr(32'h00221820, 1'b0, 1, 1'b0);
        run_instr(32'h00221820, 1'b0, 4, 1'b1);
        run_instr(32'h00221820, 1'b0, int'(TO), 1'b0);
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                ir = $urandom;
                ir[31:26] = rbit() ? 6'h04 : 6'h05;
                run_instr(ir, rbit(), 0, 1'b0);
            end else if (r < 35) begin
                ir = $urandom;
                ir[31:26] = rbit() ? 6'h02 : 6'h03;
                run_instr(ir, rbit(), 0, 1'b0);
            end else if (r < 45) begin
                ir = $urandom;
                ir[31:26] = 6'h00; ir[5:0] = 6'h08;
                run_instr(ir, rbit(), 0, 1'b0);
            end else if (r < 48) begin
                ir = $urandom;
                ir[31:26] = 6'h00; ir[5:0] = 6'h0D;
                run_instr(ir, rbit(), 0, 1'b0);
            end else begin
                do ir = $urandom; while (kind(ir) != K_EX);
                if (r < 52)
                    run_instr(ir, rbit(), 0, 1'b0);
                else if (r < 55)
                    run_instr(ir, rbit(), 2, 1'b1);
                else
                    run_instr(ir, rbit(), int'($urandom_range(1, TO)), 1'b0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_sequencer.md
Name: fetch_decode_sequencer

Overview:
- Multi-cycle control FSM that directly drives the instruction unit: PC load/increment, PC mux select, instruction memory strobes and IR load.
- Consumes the IR contents that the instruction unit produces.
- Decides the next-PC source for beq/bne/j/jal/jr.
- Hands all other instructions to the execute stage over a req/done handshake.

Parameters:
- BREAK_FUNCT, 6'h0D: R-type funct code that halts the sequencer.
- EX_TIMEOUT, 16: maximum cycles ex_req may stay high without ex_done before an error halt. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IR_out  in  32  current instruction from IR
- br_eq  in  1  rs==rt compare from the register file, valid in BRANCH
- ex_done  in  1  execute stage finished the current instruction
- PC_ld  out  1  load PC from the PC mux
- PC_inc  out  1  PC <= PC+4
- PC_sel  out  2  00 branch target, 01 jump target, 10 PC_in, 11 PC_jr
- IM_cs  out  1  instruction memory chip select
- IM_rd  out  1  instruction memory read
- IR_ld  out  1  load IR
- ex_req  out  1  execute request, held until ex_done
- link_we  out  1  one-cycle pulse: write PC (already +4) to $31 for jal
- halted  out  1  sequencer stopped
- err  out  1  halt was caused by a timeout

Behaviour:
- States: IDLE, FETCH, DECODE, BRANCH, JUMP, JR, EXEC, HALT.
- Reset: reset low asynchronously forces IDLE with every output 0 and the timeout counter 0. Reset mid-instruction abandons it; no partial ex_req or PC_ld may survive.
- IDLE: entered on reset. Goes to FETCH on the first clock after reset deasserts. All outputs 0.
- FETCH (1 cycle): IM_cs=IM_rd=IR_ld=PC_inc=1, PC_ld=0. Next state DECODE. After FETCH, PC holds fetch address + 4.
- DECODE (1 cycle, no strobes): opcode = IR_out[31:26], funct = IR_out[5:0].
  - 6'h04 or 6'h05 -> BRANCH
  - 6'h02 or 6'h03 -> JUMP
  - 6'h00 with funct 6'h08 -> JR
  - 6'h00 with funct BREAK_FUNCT -> HALT, err=0
  - anything else -> EXEC
- BRANCH (1 cycle): PC_sel=00. PC_ld = br_eq for beq, ~br_eq for bne. Next state FETCH. A not-taken branch leaves PC at +4.
- JUMP (1 cycle): PC_sel=01, PC_ld=1. For opcode 6'h03, link_we=1 in the same cycle. Next state FETCH.
- JR (1 cycle): PC_sel=11, PC_ld=1. Next state FETCH.
- EXEC:
  - ex_req=1 while in this state.
  - ex_done sampled high at a rising edge: next state FETCH, ex_req low in the following cycle. ex_done high in the first EXEC cycle completes that same cycle (minimum EXEC length 1).
  - The counter increments each EXEC cycle without ex_done. If it reaches EX_TIMEOUT (EX_TIMEOUT != 0): go to HALT, err=1. The counter clears on leaving EXEC.
  - ex_done outside EXEC is ignored.
- HALT: halted=1, err held, all other outputs 0. Left only through reset.
- Output timing:
  - Outputs are combinational from state plus IR_out/br_eq only.
  - PC_sel = 00 in every state that does not assert PC_ld.
  - PC_ld and PC_inc are never both 1.
- Instruction cost: 3 cycles for branch/jump/jr; 2 + EXEC length for others.

Optional Feature:
- Macro FDS_PERF_CNT_EN.
- When defined:
  - Adds output retired_cnt [31:0], cleared by reset.
  - Increments by 1 on leaving BRANCH, JUMP or JR, and on leaving EXEC via ex_done.
  - Not incremented on entering HALT or on timeout.
  - Wraps 32'hFFFFFFFF -> 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then release, IR_out=32'h00000000 (sll, goes to EXEC), ex_done asserted on the 3rd EXEC cycle:
  - FETCH strobes all 1 for exactly one cycle.
  - ex_req high for 3 cycles.
  - FETCH again 1 cycle later.
- beq IR_out=32'h1000FFFF:
  - br_eq=1: PC_ld=1, PC_sel=00 in BRANCH.
  - br_eq=0: PC_ld=0.
  - bne IR_out=32'h1400FFFF with br_eq=0: PC_ld=1.
- jal IR_out=32'h0C000010: in JUMP, PC_sel=01, PC_ld=1, link_we=1 for exactly one cycle. jr IR_out=32'h03E00008: PC_sel=11, PC_ld=1.
- break IR_out=32'h0000000D: halted=1, err=0. Outputs stay 0 for 20 cycles with ex_done toggling. Reset low recovers to IDLE.
- EX_TIMEOUT=16, addi IR_out=32'h20010005, ex_done never asserted: after 16 EXEC cycles, halted=1, err=1, ex_req=0.
- Reset pulsed low mid-EXEC: all outputs 0 asynchronously, before the next clock edge. With FDS_PERF_CNT_EN, retired_cnt=0 after reset and equals 3 after jal, beq, and add+ex_done.
